// File: rtl/quadrature_encoder_emulator.sv
// Quadrature encoder emulator: phase accumulator turns a signed RPM setpoint into A/B edges,
// a Step strobe and a signed position count. Define ENCODER_INDEX_EN for the once-per-rev Index.
module quadrature_encoder_emulator #(
  parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
  parameter int unsigned COUNTS_PER_REV = 38400
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Enable,
  input  logic signed [15:0] RPM_Setpoint,
  output logic               Encoder_A,
  output logic               Encoder_B,
  output logic               Index,
  output logic               Step,
  output logic signed [32:0] count
);

  localparam logic [39:0] Mod     = 40'(CLK_FREQ_HZ) * 40'd60;
  localparam logic [47:0] ModWide = 48'(Mod);

  // Encoded as {A,B} so the state register drives the outputs directly.
  typedef enum logic [1:0] {
    StS0 = 2'b00,
    StS1 = 2'b10,
    StS2 = 2'b11,
    StS3 = 2'b01
  } quad_state_e;

  logic signed [15:0] rpm_q;
  logic               en_q;
  logic [39:0]        acc_q, acc_d;
  quad_state_e        state_q, state_d;
  logic               step_q;
  logic signed [32:0] count_q, count_d;

  logic [16:0] mag;
  logic        dir;
  logic [47:0] prod;
  logic [39:0] inc;
  logic [39:0] sum;
  logic        active;
  logic        step_now;

  always_comb begin
    mag      = rpm_q[15] ? (17'd0 - {1'b1, rpm_q}) : {1'b0, rpm_q};
    dir      = ~rpm_q[15];
    prod     = 48'(mag) * 48'(COUNTS_PER_REV);
    // Clamping to Mod caps the output at one edge per clock.
    inc      = (prod >= ModWide) ? Mod : prod[39:0];
    sum      = acc_q + inc;
    active   = en_q && (mag != 17'd0);
    step_now = active && (sum >= Mod);
  end

  always_comb begin
    acc_d   = acc_q;
    state_d = state_q;
    count_d = count_q;
    if (active) begin
      acc_d = step_now ? (sum - Mod) : sum;
    end
    if (step_now) begin
      unique case (state_q)
        StS0: state_d = dir ? StS1 : StS3;
        StS1: state_d = dir ? StS2 : StS0;
        StS2: state_d = dir ? StS3 : StS1;
        StS3: state_d = dir ? StS0 : StS2;
      endcase
      count_d = dir ? (count_q + 33'sd1) : (count_q - 33'sd1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpm_q   <= '0;
      en_q    <= 1'b0;
      acc_q   <= '0;
      state_q <= StS0;
      step_q  <= 1'b0;
      count_q <= '0;
    end else begin
      rpm_q   <= RPM_Setpoint;
      en_q    <= Enable;
      acc_q   <= acc_d;
      state_q <= state_d;
      step_q  <= step_now;
      count_q <= count_d;
    end
  end

  assign Encoder_A = state_q[1];
  assign Encoder_B = state_q[0];
  assign Step      = step_q;
  assign count     = count_q;

`ifdef ENCODER_INDEX_EN
  localparam int unsigned RevW = (COUNTS_PER_REV > 1) ? $clog2(COUNTS_PER_REV) : 1;
  localparam logic [RevW-1:0] RevMax = RevW'(COUNTS_PER_REV - 1);

  logic [RevW-1:0] rev_pos_q, rev_pos_d;

  always_comb begin
    rev_pos_d = rev_pos_q;
    if (step_now) begin
      if (dir) begin
        rev_pos_d = (rev_pos_q == RevMax) ? '0 : rev_pos_q + 1'b1;
      end else begin
        rev_pos_d = (rev_pos_q == '0) ? RevMax : rev_pos_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rev_pos_q <= '0;
    end else begin
      rev_pos_q <= rev_pos_d;
    end
  end

  assign Index = (rev_pos_q == '0);
`else
  assign Index = 1'b0;
`endif

endmodule

// File: tb/tb_quadrature_encoder_emulator.sv
// Scoreboard bench for quadrature_encoder_emulator: an arithmetic reference model pushes the
// expected outputs each clock and a negedge monitor pops and compares them against the DUT.
module tb_quadrature_encoder_emulator;

  localparam int unsigned ClkHz = 100_000;
  localparam int unsigned Cpr   = 2000;
  localparam longint      ModL  = longint'(ClkHz) * 60;

`ifdef ENCODER_INDEX_EN
  localparam bit IdxEn = 1'b1;
`else
  localparam bit IdxEn = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               Enable;
  logic signed [15:0] RPM_Setpoint;
  logic               Encoder_A;
  logic               Encoder_B;
  logic               Index;
  logic               Step;
  logic signed [32:0] count;

  quadrature_encoder_emulator #(
    .CLK_FREQ_HZ   (ClkHz),
    .COUNTS_PER_REV(Cpr)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Enable      (Enable),
    .RPM_Setpoint(RPM_Setpoint),
    .Encoder_A   (Encoder_A),
    .Encoder_B   (Encoder_B),
    .Index       (Index),
    .Step        (Step),
    .count       (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        a;
    logic        b;
    logic        idx;
    logic        stp;
    logic [32:0] cnt;
    bit          rst;
  } exp_t;

  exp_t exp_q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   sampled = 0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Reference model: position as an integer walked around the gray table.
  initial begin
    logic [1:0] ab_seq [4];
    longint     m_acc, m_cnt, mag, inc;
    int         m_pos, m_rev, m_rpm;
    bit         m_en, m_step, stepped;
    exp_t       e;
    ab_seq = '{2'b00, 2'b10, 2'b11, 2'b01};
    m_acc = 0; m_cnt = 0; m_pos = 0; m_rev = 0; m_rpm = 0; m_en = 0; m_step = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_acc = 0; m_cnt = 0; m_pos = 0; m_rev = 0; m_rpm = 0; m_en = 0; m_step = 0;
      end else begin
        mag = (m_rpm < 0) ? -m_rpm : m_rpm;
        inc = mag * Cpr;
        if (inc > ModL) inc = ModL;
        stepped = 0;
        if (m_en && mag != 0) begin
          m_acc += inc;
          if (m_acc >= ModL) begin
            m_acc  -= ModL;
            stepped = 1;
          end
        end
        if (stepped) begin
          if (m_rpm >= 0) begin
            m_pos = (m_pos + 1) % 4;
            m_cnt = m_cnt + 1;
            m_rev = (m_rev + 1) % Cpr;
          end else begin
            m_pos = (m_pos + 3) % 4;
            m_cnt = m_cnt - 1;
            m_rev = (m_rev + Cpr - 1) % Cpr;
          end
        end
        m_step = stepped;
        m_rpm  = int'(RPM_Setpoint);
        m_en   = Enable;
      end
      e.a   = ab_seq[m_pos][1];
      e.b   = ab_seq[m_pos][0];
      e.idx = IdxEn && (m_rev == 0);
      e.stp = m_step;
      e.cnt = 33'(m_cnt);
      e.rst = reset;
      exp_q.push_back(e);
    end
  end

  // Monitor: compare away from the active edge.
  initial begin
    exp_t       e;
    logic [1:0] prev_ab;
    bit         prev_valid;
    prev_valid = 0;
    prev_ab    = 2'b00;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        sampled++;
        chk("enc_a", 33'(Encoder_A), 33'(e.a));
        chk("enc_b", 33'(Encoder_B), 33'(e.b));
        chk("index", 33'(Index), 33'(e.idx));
        chk("step", 33'(Step), 33'(e.stp));
        chk("count", count, e.cnt);
        if (prev_valid && !e.rst) begin
          chk("ab_single_toggle", 33'(((prev_ab ^ {Encoder_A, Encoder_B}) == 2'b11)), 33'd0);
        end
        prev_ab    = {Encoder_A, Encoder_B};
        prev_valid = 1;
      end
    end
  end

  task automatic run(input int n, input int rpm, input bit en);
    RPM_Setpoint = 16'(rpm);
    Enable       = en;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic signed [15:0] r;
    bit                 en;
    int                 len;
    reset        = 1'b1;
    Enable       = 1'b0;
    RPM_Setpoint = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    run(3100, 1, 1);       // one step every 3000 clocks
    run(4500, 3125, 1);    // clamped: one step per clock, wraps rev_pos twice
    run(600, -100, 1);     // reverse, step every 30 clocks
    run(100, 1500, 1);
    run(100, -1500, 1);    // reversal mid-run
    run(200, -1500, 0);    // frozen
    run(200, -1500, 1);
    run(300, -32768, 1);   // most negative setpoint
    run(50, 0, 1);

    for (int i = 0; i < 40; i++) begin
      r   = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) r = 16'(int'($urandom_range(0, 400)) - 200);
      en  = ($urandom_range(0, 7) != 0);
      len = int'($urandom_range(20, 300));
      run(len, int'(r), en);
    end

    // Asynchronous reset mid-cycle.
    run(37, 2000, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_a", 33'(Encoder_A), 33'd0);
    chk("async_rst_b", 33'(Encoder_B), 33'd0);
    chk("async_rst_step", 33'(Step), 33'd0);
    chk("async_rst_count", count, 33'd0);
    chk("async_rst_index", 33'(Index), 33'(IdxEn));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run(300, 2000, 1);

    run(2, 0, 0);
    chk("queue_drained", 33'(exp_q.size() <= 1), 33'd1);
    chk("monitor_active", 33'(sampled > 10000), 33'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
